// File: rtl/onchip_ram_arbiter_if.sv
// Avalon-MM master-side bundle for one port of the on-chip RAM arbiter.
// The arbiter connects to each master through the slave modport.
interface onchip_ram_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
);
  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/onchip_ram_arbiter.sv
// Two-master round-robin arbiter and zero-fill initialiser for a single-port
// on-chip RAM with fixed read latency of one cycle and clock-enable hold-off.
module onchip_ram_arbiter #(
  parameter int ADDR_W         = 10,
  parameter int DATA_W         = 32,
  parameter int BE_W           = 4,
  parameter int DEPTH          = 1024,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 reset_req,
  onchip_ram_arbiter_if.slave  m0,
  onchip_ram_arbiter_if.slave  m1,
  output logic [ADDR_W-1:0]    ram_address,
  output logic [BE_W-1:0]      ram_byteenable,
  output logic                 ram_chipselect,
  output logic                 ram_write,
  output logic [DATA_W-1:0]    ram_writedata,
  input  logic [DATA_W-1:0]    ram_readdata,
  output logic                 ram_clken,
  output logic                 init_done
);

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] init_cnt;
  logic              last_grant;
  logic              req0, req1;
  logic              init_en, run_en;
  logic              grant0, grant1;
  logic              vld_p1, owner_p1;

  assign ram_clken = ~reset_req;
  assign req0      = m0.read | m0.write;
  assign req1      = m1.read | m1.write;
  assign init_en   = (state == INIT) & ~reset & ~reset_req;
  assign run_en    = (state == RUN) & ~reset & ~reset_req;

  // last_grant = 1 means m1 won last, so m0 takes the next contended slot
  assign grant0 = run_en & req0 & (~req1 | last_grant);
  assign grant1 = run_en & req1 & (~req0 | ~last_grant);

  assign m0.waitrequest = reset | (state == INIT) | (req0 & ~grant0);
  assign m1.waitrequest = reset | (state == INIT) | (req1 & ~grant1);

  assign m0.readdata      = ram_readdata;
  assign m1.readdata      = ram_readdata;
  assign m0.readdatavalid = vld_p1 & ~owner_p1;
  assign m1.readdatavalid = vld_p1 & owner_p1;

  always_comb begin
    ram_chipselect = 1'b0;
    ram_write      = 1'b0;
    ram_address    = '0;
    ram_byteenable = '0;
    ram_writedata  = '0;
    if (init_en) begin
      ram_chipselect = 1'b1;
      ram_write      = 1'b1;
      ram_address    = init_cnt;
      ram_byteenable = '1;
    end else if (grant0) begin
      ram_chipselect = 1'b1;
      ram_write      = m0.write;
      ram_address    = m0.address;
      ram_byteenable = m0.byteenable;
      ram_writedata  = m0.writedata;
    end else if (grant1) begin
      ram_chipselect = 1'b1;
      ram_write      = m1.write;
      ram_address    = m1.address;
      ram_byteenable = m1.byteenable;
      ram_writedata  = m1.writedata;
    end
  end

  // p0 -> p1: FSM, init counter, arbitration history and read-valid owner
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= CLEAR_ON_RESET ? INIT : RUN;
      init_cnt   <= '0;
      last_grant <= 1'b1;
      vld_p1     <= 1'b0;
      owner_p1   <= 1'b0;
      init_done  <= 1'b0;
    end else begin
      // A read+write from one master is a write; it never produces read data
      vld_p1   <= (grant0 & ~m0.write) | (grant1 & ~m1.write);
      owner_p1 <= grant1;
      case (state)
        INIT: begin
          if (!reset_req) begin
            init_cnt <= init_cnt + 1'b1;
            if (init_cnt == LAST_ADDR) begin
              state     <= RUN;
              init_done <= 1'b1;
            end
          end
        end
        RUN: begin
          init_done <= 1'b1;
          if (grant0)      last_grant <= 1'b0;
          else if (grant1) last_grant <= 1'b1;
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_onchip_ram_arbiter.sv
// Directed bench for onchip_ram_arbiter: init fill, arbitration, latency,
// byte lanes, reset_req hold-off and mid-operation reset, against a RAM model.
module tb_onchip_ram_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        reset_req;
  logic [9:0]  ram_address;
  logic [3:0]  ram_byteenable;
  logic        ram_chipselect;
  logic        ram_write;
  logic [31:0] ram_writedata;
  logic [31:0] ram_readdata;
  logic        ram_clken;
  logic        init_done;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:1023];

  onchip_ram_arbiter_if #(.ADDR_W(10), .DATA_W(32), .BE_W(4)) m0_bus ();
  onchip_ram_arbiter_if #(.ADDR_W(10), .DATA_W(32), .BE_W(4)) m1_bus ();

  onchip_ram_arbiter #(
    .ADDR_W(10), .DATA_W(32), .BE_W(4), .DEPTH(1024), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .reset_req(reset_req),
    .m0(m0_bus), .m1(m1_bus),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable),
    .ram_chipselect(ram_chipselect), .ram_write(ram_write),
    .ram_writedata(ram_writedata), .ram_readdata(ram_readdata),
    .ram_clken(ram_clken), .init_done(init_done)
  );

  always #5 clk = ~clk;

  // Single-port RAM model: registered read, byte-lane writes, held by clken
  always @(posedge clk) begin
    if (ram_clken && ram_chipselect) begin
      if (ram_write) begin
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
      end else begin
        ram_readdata <= mem[ram_address];
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    m0_bus.read = 1'b0; m0_bus.write = 1'b0; m0_bus.address = '0;
    m0_bus.byteenable = 4'hF; m0_bus.writedata = '0;
    m1_bus.read = 1'b0; m1_bus.write = 1'b0; m1_bus.address = '0;
    m1_bus.byteenable = 4'hF; m1_bus.writedata = '0;
  endtask

  task automatic test_reset;
    reset = 1'b1; reset_req = 1'b0;
    idle();
    m0_bus.read = 1'b1;
    tick(); tick(); tick();
    #1;
    total++; if (m0_bus.waitrequest !== 1'b1) begin bad++; $display("FAIL rst_wait0 got=%b exp=1", m0_bus.waitrequest); end
    total++; if (m1_bus.waitrequest !== 1'b1) begin bad++; $display("FAIL rst_wait1 got=%b exp=1", m1_bus.waitrequest); end
    total++; if (ram_chipselect !== 1'b0 || ram_write !== 1'b0) begin bad++; $display("FAIL rst_ram cs=%b wr=%b exp=0/0", ram_chipselect, ram_write); end
    total++; if (m0_bus.readdatavalid !== 1'b0 || m1_bus.readdatavalid !== 1'b0) begin bad++; $display("FAIL rst_rdv got=%b%b exp=00", m0_bus.readdatavalid, m1_bus.readdatavalid); end
    total++; if (init_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", init_done); end
    idle();
  endtask

  task automatic test_init;
    int writes = 0, addr_bad = 0, wait_bad = 0, done_c = 0;
    reset = 1'b0;
    for (int c = 1; c <= 1200; c++) begin
      #1;
      if (init_done === 1'b1) begin done_c = c; break; end
      if (!(ram_chipselect === 1'b1 && ram_write === 1'b1) || ram_address !== 10'(c - 1) ||
          ram_byteenable !== 4'hF || ram_writedata !== 32'h0) addr_bad++;
      else writes++;
      if (m0_bus.waitrequest !== 1'b1 || m1_bus.waitrequest !== 1'b1) wait_bad++;
      tick();
    end
    total++; if (writes != 1024) begin bad++; $display("FAIL init_writes got=%0d exp=1024", writes); end
    total++; if (addr_bad != 0) begin bad++; $display("FAIL init_addr bad_cycles=%0d exp=0", addr_bad); end
    total++; if (done_c != 1025) begin bad++; $display("FAIL init_done_cycle got=%0d exp=1025", done_c); end
    total++; if (wait_bad != 0) begin bad++; $display("FAIL init_wait bad_cycles=%0d exp=0", wait_bad); end
  endtask

  task automatic test_read_after_init;
    tick();
    m0_bus.read = 1'b1; m0_bus.address = 10'd5;
    #1;
    total++; if (m0_bus.waitrequest !== 1'b0 || ram_chipselect !== 1'b1 || ram_write !== 1'b0) begin bad++; $display("FAIL rd5_grant wait=%b cs=%b wr=%b exp=0/1/0", m0_bus.waitrequest, ram_chipselect, ram_write); end
    tick();
    idle();
    #1;
    total++; if (m0_bus.readdatavalid !== 1'b1 || m0_bus.readdata !== 32'h0) begin bad++; $display("FAIL rd5_data vld=%b data=%h exp=1/00000000", m0_bus.readdatavalid, m0_bus.readdata); end
  endtask

  task automatic test_write_read;
    m0_bus.write = 1'b1; m0_bus.address = 10'd3; m0_bus.writedata = 32'hDEADBEEF;
    tick();
    idle();
    m1_bus.read = 1'b1; m1_bus.address = 10'd3;
    #1;
    total++; if (m1_bus.waitrequest !== 1'b0) begin bad++; $display("FAIL wr_rd_grant got=%b exp=0", m1_bus.waitrequest); end
    total++; if (m0_bus.readdatavalid !== 1'b0) begin bad++; $display("FAIL wr_no_rdv got=%b exp=0", m0_bus.readdatavalid); end
    tick();
    idle();
    #1;
    total++; if (m1_bus.readdatavalid !== 1'b1 || m1_bus.readdata !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_rd_data vld=%b data=%h exp=1/deadbeef", m1_bus.readdatavalid, m1_bus.readdata); end
    total++; if (m0_bus.readdatavalid !== 1'b0) begin bad++; $display("FAIL wr_rd_owner got=%b exp=0", m0_bus.readdatavalid); end
  endtask

  task automatic test_contention;
    int errs = 0;
    m0_bus.read = 1'b1; m0_bus.address = 10'd3;
    m1_bus.read = 1'b1; m1_bus.address = 10'd5;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (m0_bus.waitrequest !== (k % 2 == 1)) errs++;
      if (m1_bus.waitrequest !== (k % 2 == 0)) errs++;
      if (ram_address !== ((k % 2 == 0) ? 10'd3 : 10'd5)) errs++;
      if (k > 0) begin
        if (m0_bus.readdatavalid !== ((k - 1) % 2 == 0)) errs++;
        if (m1_bus.readdatavalid !== ((k - 1) % 2 == 1)) errs++;
        if (m0_bus.readdatavalid === 1'b1 && m0_bus.readdata !== 32'hDEADBEEF) errs++;
        if (m1_bus.readdatavalid === 1'b1 && m1_bus.readdata !== 32'h0) errs++;
      end
      tick();
    end
    idle();
    #1;
    total++; if (errs != 0) begin bad++; $display("FAIL rr_alternate errors=%0d exp=0", errs); end
    total++; if (m1_bus.readdatavalid !== 1'b1 || m0_bus.readdatavalid !== 1'b0) begin bad++; $display("FAIL rr_last_rdv got=%b%b exp=01", m0_bus.readdatavalid, m1_bus.readdatavalid); end
  endtask

  task automatic test_byte_write;
    m1_bus.write = 1'b1; m1_bus.address = 10'd7; m1_bus.writedata = 32'h11223344;
    tick();
    idle();
    m0_bus.write = 1'b1; m0_bus.address = 10'd7; m0_bus.byteenable = 4'b0010;
    m0_bus.writedata = 32'h0000AB00;
    #1;
    total++; if (ram_byteenable !== 4'b0010) begin bad++; $display("FAIL bw_lanes got=%b exp=0010", ram_byteenable); end
    tick();
    idle();
    m0_bus.read = 1'b1; m0_bus.address = 10'd7;
    tick();
    idle();
    #1;
    total++; if (m0_bus.readdatavalid !== 1'b1 || m0_bus.readdata !== 32'h1122AB44) begin bad++; $display("FAIL bw_data vld=%b data=%h exp=1/1122ab44", m0_bus.readdatavalid, m0_bus.readdata); end
  endtask

  task automatic test_protocol_error;
    m0_bus.read = 1'b1; m0_bus.write = 1'b1; m0_bus.address = 10'd9;
    m0_bus.writedata = 32'h12345678;
    $display("note: m0 drives read and write together (protocol error), expected to act as a write");
    #1;
    total++; if (ram_chipselect !== 1'b1 || ram_write !== 1'b1) begin bad++; $display("FAIL proto_write cs=%b wr=%b exp=1/1", ram_chipselect, ram_write); end
    tick();
    idle();
    m0_bus.read = 1'b1; m0_bus.address = 10'd9;
    #1;
    total++; if (m0_bus.readdatavalid !== 1'b0) begin bad++; $display("FAIL proto_no_rdv got=%b exp=0", m0_bus.readdatavalid); end
    tick();
    idle();
    #1;
    total++; if (m0_bus.readdatavalid !== 1'b1 || m0_bus.readdata !== 32'h12345678) begin bad++; $display("FAIL proto_data vld=%b data=%h exp=1/12345678", m0_bus.readdatavalid, m0_bus.readdata); end
  endtask

  task automatic test_reset_req_run;
    reset_req = 1'b1;
    m1_bus.read = 1'b1; m1_bus.address = 10'd3;
    #1;
    total++; if (m1_bus.waitrequest !== 1'b1) begin bad++; $display("FAIL rreq_wait1 got=%b exp=1", m1_bus.waitrequest); end
    total++; if (ram_chipselect !== 1'b0 || ram_clken !== 1'b0) begin bad++; $display("FAIL rreq_ram cs=%b clken=%b exp=0/0", ram_chipselect, ram_clken); end
    tick();
    #1;
    total++; if (m1_bus.readdatavalid !== 1'b0) begin bad++; $display("FAIL rreq_no_rdv got=%b exp=0", m1_bus.readdatavalid); end
    reset_req = 1'b0;
    idle();
    tick();
  endtask

  task automatic test_reset_mid;
    m0_bus.read = 1'b1; m0_bus.address = 10'd5;
    #1;
    total++; if (m0_bus.waitrequest !== 1'b0) begin bad++; $display("FAIL mid_grant got=%b exp=0", m0_bus.waitrequest); end
    tick();
    reset = 1'b1;
    m1_bus.read = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    total++; if (m0_bus.readdatavalid !== 1'b0) begin bad++; $display("FAIL mid_rdv_drop got=%b exp=0", m0_bus.readdatavalid); end
    total++; if (init_done !== 1'b0) begin bad++; $display("FAIL mid_done got=%b exp=0", init_done); end
    total++; if (ram_chipselect !== 1'b1 || ram_write !== 1'b1 || ram_address !== 10'd0) begin bad++; $display("FAIL mid_init0 cs=%b wr=%b addr=%0d exp=1/1/0", ram_chipselect, ram_write, ram_address); end
    total++; if (m0_bus.waitrequest !== 1'b1 || m1_bus.waitrequest !== 1'b1) begin bad++; $display("FAIL mid_wait got=%b%b exp=11", m0_bus.waitrequest, m1_bus.waitrequest); end
    idle();
  endtask

  task automatic test_reset_req_init;
    int writes = 0, addr_bad = 0, paused_bad = 0, done_c = 0;
    for (int c = 1; c <= 1200; c++) begin
      reset_req = (c >= 101 && c <= 103);
      #1;
      if (init_done === 1'b1) begin done_c = c; break; end
      if (reset_req) begin
        if (ram_clken !== 1'b0 || ram_chipselect !== 1'b0 || ram_write !== 1'b0) paused_bad++;
      end else if (!(ram_chipselect === 1'b1 && ram_write === 1'b1) ||
                   ram_address !== 10'((c <= 100) ? c - 1 : c - 4)) begin
        addr_bad++;
      end else begin
        writes++;
      end
      tick();
    end
    reset_req = 1'b0;
    total++; if (paused_bad != 0) begin bad++; $display("FAIL hold_pause bad_cycles=%0d exp=0", paused_bad); end
    total++; if (addr_bad != 0) begin bad++; $display("FAIL hold_addr bad_cycles=%0d exp=0", addr_bad); end
    total++; if (writes != 1024) begin bad++; $display("FAIL hold_writes got=%0d exp=1024", writes); end
    total++; if (done_c != 1028) begin bad++; $display("FAIL hold_done_cycle got=%0d exp=1028", done_c); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_read_after_init();
    test_write_read();
    test_contention();
    test_byte_write();
    test_protocol_error();
    test_reset_req_run();
    test_reset_mid();
    test_reset_req_init();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/onchip_ram_arbiter.md
Name: onchip_ram_arbiter

Overview:
Two-master arbiter and initialiser for the single-port 1024x32 on-chip RAM. It sits between two Avalon-MM masters (m0, m1) and the RAM's one port (address, byteenable, chipselect, write, writedata, readdata, clken). It optionally zero-fills the RAM after reset, applies round-robin arbitration, and returns read data with fixed latency 1. It also honours the RAM's reset_req hold-off.

Parameters:
ADDR_W, 10, word address width
DATA_W, 32, data width
BE_W, 4, byteenable width (DATA_W/8)
DEPTH, 1024, words to clear during init (must be <= 2**ADDR_W)
CLEAR_ON_RESET, 1, 1 = zero-fill the RAM after reset; 0 = go straight to RUN

Ports:
clk  in  1  single clock
reset  in  1  synchronous, active-high reset
reset_req  in  1  RAM hold-off request; while high, no accesses and RAM clock enable is low
mX_address  in  ADDR_W  master X word address (X = 0,1)
mX_byteenable  in  BE_W  master X byte lanes
mX_read  in  1  master X read request
mX_write  in  1  master X write request
mX_writedata  in  DATA_W  master X write data
mX_waitrequest  out  1  master X stall
mX_readdata  out  DATA_W  master X read data
mX_readdatavalid  out  1  master X read data valid
ram_address  out  ADDR_W  to RAM
ram_byteenable  out  BE_W  to RAM
ram_chipselect  out  1  to RAM
ram_write  out  1  to RAM
ram_writedata  out  DATA_W  to RAM
ram_readdata  in  DATA_W  from RAM; valid the cycle after the address is clocked
ram_clken  out  1  RAM clock enable, equal to ~reset_req
init_done  out  1  high once in RUN

Behaviour:
- Single clock, clk. Reset is synchronous and active-high on reset; no asynchronous reset anywhere.
- Reset state:
  - FSM = INIT if CLEAR_ON_RESET, else RUN.
  - init counter = 0; last_grant = 1, so m0 wins the first contention.
  - mX_readdatavalid = 0; init_done = 0.
  - ram_chipselect = 0; ram_write = 0.
  - mX_waitrequest = 1 while reset is high.
- FSM INIT:
  - Each cycle with reset_req = 0: ram_chipselect = 1, ram_write = 1, ram_address = counter, ram_byteenable = all ones, ram_writedata = 0; counter increments.
  - Writing DEPTH-1 moves the FSM to RUN on the next edge.
  - reset_req = 1 pauses the counter; no write is issued that cycle.
  - All mX_waitrequest = 1 during INIT.
- FSM RUN:
  - init_done = 1.
  - reqX = mX_read | mX_write.
  - Grant is combinational each cycle, and only when reset_req = 0:
    - Only one master requesting: that master is granted.
    - Both requesting: grant the master not equal to last_grant.
  - last_grant <= granted master on every grant; otherwise it holds.
  - mX_waitrequest = reqX & ~grantX. It is 0 when the master is not requesting.
  - Granted access: ram_chipselect = 1; ram_address, ram_byteenable and ram_writedata are muxed from the winner; ram_write = winner's write.
  - No grant: ram_chipselect = 0, ram_write = 0.
  - Read and write asserted together by one master: treated as a write, no readdatavalid; this is a protocol error the bench must flag.
- Read latency:
  - A read granted in cycle N gives mX_readdatavalid = 1 in cycle N+1, for the owner only.
  - The valid/owner pipeline register is not gated by reset_req. The RAM address register holds while clken is low, so the data stays stable.
  - Both mX_readdata buses are driven with ram_readdata; only valid qualifies them.
- Throughput: back-to-back accesses, one per cycle, with any read/write mix. Under continuous contention, grants alternate m0, m1, m0, and so on.
- Write then read to the same address in consecutive cycles returns the new data.
- Reset mid-operation:
  - A pending readdatavalid is dropped.
  - Any in-flight INIT restarts at address 0.
  - Grants pending at reset are not retained.

Test Plan:
- CLEAR_ON_RESET=1, release reset, reset_req=0 -> exactly 1024 zero writes to addresses 0..1023 with byteenable=4'hF, then init_done=1 in cycle 1025. A later m0 read of address 5 returns 0.
- RUN, m0 writes 0xDEADBEEF to address 3, then m1 reads address 3 the next cycle -> m1_readdatavalid=1 one cycle after grant, m1_readdata=0xDEADBEEF, m0_readdatavalid=0.
- Both masters issue continuous reads for 6 cycles -> grants go m0, m1, m0, m1, m0, m1. Each master's waitrequest is high in alternate cycles, and each readdatavalid follows its grant by 1 cycle.
- Byte write with m0_byteenable=4'b0010, data 0x0000AB00, to a word holding 0x11223344 -> a subsequent read returns 0x1122AB44.
- reset_req pulsed high for 3 cycles during INIT at counter=100 -> ram_clken=0 and no writes for those cycles; INIT resumes at 100 and ends on schedule +3 cycles. reset_req high in RUN with m1 requesting -> m1_waitrequest=1 and no chipselect.
- reset asserted the cycle after an m0 read grant -> m0_readdatavalid=0 next cycle, FSM back in INIT at address 0, all waitrequests=1.
